conv1_row_window_buf: RTL

Input line buffer for the conv1 stage. It accepts a raster-order 8-bit pixel stream of a 32x32 image and stores it in a 6-slot circular row buffer. It emits one 5-row x 8-pixel window per handshake, packed as 5x64 bits. That is exactly the row data the conv1 weight/pixel routing stage slices into 4 stride-1 filter positions.

---
 rtl/conv1_row_window_buf.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/conv1_row_window_buf.sv
// conv1_row_window_buf: 6-slot circular row buffer for a 32x32 8-bit raster stream,
// emitting registered 5-row x 8-pixel windows (one per handshake) for conv1.
// Ports:
//   clk_i, rst_n_i                 clock, async active-low reset
//   pxl_i/pxl_valid_i/pxl_ready_o  raster-order pixel input stream
//   intm_row_data_o                window, row p = image row band+p, byte q = column slice*4+q
//   out_valid_o/out_ready_i        window handshake
//   out_band_o/out_slice_o         window position; out_last_o marks band 27 slice 6
module conv1_row_window_buf #(
  parameter int IMG_W         = 32,
  parameter int IMG_H         = 32,
  parameter int PXL_WIDTH     = 8,
  parameter int NUM_FILT_ROWS = 5,
  parameter int NUM_PXL       = 8,
  parameter int FILT_INST     = 4,
  parameter int DATA_WIDTH    = NUM_PXL * PXL_WIDTH
) (
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic [PXL_WIDTH-1:0]                      pxl_i,
  input  logic                                      pxl_valid_i,
  output logic                                      pxl_ready_o,
  output logic [NUM_FILT_ROWS-1:0][DATA_WIDTH-1:0]  intm_row_data_o,
  output logic                                      out_valid_o,
  input  logic                                      out_ready_i,
  output logic [4:0]                                out_band_o,
  output logic [2:0]                                out_slice_o,
  output logic                                      out_last_o
);
  localparam int SLICES    = (IMG_W - NUM_FILT_ROWS + 1) / FILT_INST;
  localparam int BANDS     = IMG_H - NUM_FILT_ROWS + 1;
  localparam int ROW_SLOTS = 6;
  localparam int CW        = $clog2(IMG_W);
  localparam int RW        = $clog2(IMG_H + 1);

  typedef enum logic [1:0] {FILL, EMIT, DONE} state_t;

  logic [PXL_WIDTH-1:0] mem_q [ROW_SLOTS][IMG_W];
  state_t state_q, state_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [RW-1:0] wr_row_q, wr_row_d, rows_stored_q, rows_stored_d, rows_retired_q, rows_retired_d;
  logic [2:0] wr_slot_q, wr_slot_d, rd_base_q, rd_base_d, slice_q, slice_d, ld_base, ld_slice;
  logic [4:0] band_q, band_d;
  logic [NUM_FILT_ROWS-1:0][DATA_WIDTH-1:0] win_q, win_d, win_ld;
  logic accept, row_done, ld;
  logic [RW-1:0] rows_avail;
  logic [3:0] slot;
  logic [CW-1:0] col;

  assign pxl_ready_o     = (rows_stored_q - rows_retired_q < RW'(ROW_SLOTS)) && (wr_row_q < RW'(IMG_H));
  assign out_valid_o     = state_q == EMIT;
  assign intm_row_data_o = win_q;
  assign out_band_o      = band_q;
  assign out_slice_o     = slice_q;
  assign out_last_o      = out_valid_o && band_q == 5'(BANDS - 1) && slice_q == 3'(SLICES - 1);

  // A band's first window only needs columns 0..7 of its newest row, which are written long
  // before that row completes, so a row completing this cycle may already count as available.
  always_comb begin
    accept         = pxl_valid_i && pxl_ready_o;
    row_done       = accept && wr_col_q == CW'(IMG_W - 1);
    rows_avail     = rows_stored_q + RW'(row_done);
    wr_col_d       = accept ? (row_done ? '0 : wr_col_q + 1'b1) : wr_col_q;
    wr_row_d       = wr_row_q + RW'(row_done);
    wr_slot_d      = row_done ? (wr_slot_q == 3'(ROW_SLOTS - 1) ? '0 : wr_slot_q + 1'b1) : wr_slot_q;
    rows_stored_d  = rows_avail;
    rows_retired_d = rows_retired_q;
    rd_base_d      = rd_base_q;
    band_d         = band_q;
    slice_d        = slice_q;
    state_d        = state_q;
    ld             = 1'b0;
    ld_base        = rd_base_q;
    ld_slice       = slice_q;
    case (state_q)
      FILL: begin
        ld      = rows_avail >= RW'(band_q) + RW'(NUM_FILT_ROWS);
        state_d = ld ? EMIT : FILL;
      end
      EMIT: if (out_ready_i) begin
        if (slice_q != 3'(SLICES - 1)) begin
          slice_d  = slice_q + 1'b1;
          ld       = 1'b1;
          ld_slice = slice_d;
        end else if (band_q == 5'(BANDS - 1)) begin
          state_d = DONE;
        end else begin
          rows_retired_d = rows_retired_q + 1'b1;
          rd_base_d      = rd_base_q == 3'(ROW_SLOTS - 1) ? '0 : rd_base_q + 1'b1;
          band_d         = band_q + 1'b1;
          slice_d        = '0;
          ld_base        = rd_base_d;
          ld_slice       = '0;
          ld             = rows_avail >= RW'(band_d) + RW'(NUM_FILT_ROWS);
          state_d        = ld ? EMIT : FILL;
        end
      end
      default: begin
        wr_col_d       = '0;
        wr_row_d       = '0;
        wr_slot_d      = '0;
        rows_stored_d  = '0;
        rows_retired_d = '0;
        rd_base_d      = '0;
        band_d         = '0;
        slice_d        = '0;
        state_d        = FILL;
      end
    endcase
  end

  always_comb begin
    win_ld = '0;
    slot   = '0;
    col    = '0;
    for (int p = 0; p < NUM_FILT_ROWS; p++) begin
      for (int k = 0; k < NUM_PXL; k++) begin
        slot = 4'(ld_base) + 4'(p);
        slot = slot >= 4'(ROW_SLOTS) ? slot - 4'(ROW_SLOTS) : slot;
        col  = CW'(32'(ld_slice) * FILT_INST + k);
        win_ld[p][k*PXL_WIDTH +: PXL_WIDTH] = mem_q[slot[2:0]][col];
      end
    end
    win_d = ld ? win_ld : win_q;
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wr_slot_q][wr_col_q] <= pxl_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= FILL;
      wr_col_q       <= '0;
      wr_row_q       <= '0;
      wr_slot_q      <= '0;
      rows_stored_q  <= '0;
      rows_retired_q <= '0;
      rd_base_q      <= '0;
      band_q         <= '0;
      slice_q        <= '0;
      win_q          <= '0;
    end else begin
      state_q        <= state_d;
      wr_col_q       <= wr_col_d;
      wr_row_q       <= wr_row_d;
      wr_slot_q      <= wr_slot_d;
      rows_stored_q  <= rows_stored_d;
      rows_retired_q <= rows_retired_d;
      rd_base_q      <= rd_base_d;
      band_q         <= band_d;
      slice_q        <= slice_d;
      win_q          <= win_d;
    end
  end
endmodule
